uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx -- oversampling asynchronous serial receiver with a valid/ready output.
//
// Frame format: one start bit (0), DATA_WIDTH payload bits sent LSB first,
// one stop bit (1). No parity. The line idles high.
//
// Ports:
//   clk        in   1           single clock, all logic on its rising edge
//   reset      in   1           synchronous active-high reset
//   ena        in   1           receiver enable; low aborts any frame in flight
//   rxd        in   1           asynchronous serial line, idle high
//   rx_data    out  DATA_WIDTH  last accepted payload
//   rx_valid   out  1           rx_data holds a frame not yet consumed
//   rx_ready   in   1           consumer takes rx_data this cycle
//   frame_err  out  1           one-cycle pulse when a stop bit samples low
//   overrun    out  1           one-cycle pulse when a good frame is dropped
//                               because the previous one was still unconsumed
//
// Timing: after the start edge is seen on the synchronized line, the start
// bit is re-checked HALF_PULSE_WIDTH cycles later (its middle). Every later
// sample is PULSE_WIDTH cycles after the previous one, so all samples land
// near bit centres. The baud counter restarts at each sample point, so the
// only timing error is the integer truncation of PULSE_WIDTH.

module uart_rx #(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = 115_200,
   parameter int CLK_FREQ   = 50_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ena,
   input  logic                  rxd,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  frame_err,
   output logic                  overrun
);

   localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
   localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
   localparam int CNT_W            = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
   localparam int IDX_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   // Terminal counts: a count of N cycles ends when the counter shows N-1.
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
   localparam logic [CNT_W-1:0] HALF_LAST  =
      CNT_W'((HALF_PULSE_WIDTH > 0) ? (HALF_PULSE_WIDTH - 1) : 0);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);

   localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
   localparam logic [IDX_W-1:0]      IDX_ZERO  = {IDX_W{1'b0}};
   localparam logic [IDX_W-1:0]      IDX_ONE   = IDX_W'(1);
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                state_q,     state_d;
   logic [CNT_W-1:0]      cnt_q,       cnt_d;
   logic [IDX_W-1:0]      idx_q,       idx_d;
   logic [DATA_WIDTH-1:0] shift_q,     shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q,   rx_data_d;
   logic                  rx_valid_q,  rx_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q,   overrun_d;
   logic                  meta_q,      meta_d;
   logic                  rxs_q,       rxs_d;

   // New bit on top, payload one place down: built wide so it also works for DATA_WIDTH == 1.
   logic [DATA_WIDTH:0]   shift_in_s;
   // rx_valid after the consumer handshake alone, before any new frame lands.
   logic                  hs_valid_s;

   assign shift_in_s = {rxs_q, shift_q};

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

   // Next-state logic: synchronizer, bit-timing FSM, output register and handshake.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      meta_d      = rxd;
      rxs_d       = meta_q;

      // A ready with nothing valid is harmless: it only clears a set flag.
      if (rx_valid_q && rx_ready) begin
         hs_valid_s = 1'b0;
      end else begin
         hs_valid_s = rx_valid_q;
      end
      rx_valid_d = hs_valid_s;

      case (state_q)
         IDLE: begin
            cnt_d = CNT_ZERO;
            if (!rxs_q && ena) begin
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end

         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = CNT_ZERO;
               idx_d = IDX_ZERO;
               // Still low at mid-bit: a real start bit. High: a glitch, ignore it.
               if (!rxs_q) begin
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         DATA: begin
            if (cnt_q == PULSE_LAST) begin
               cnt_d   = CNT_ZERO;
               shift_d = shift_in_s[DATA_WIDTH:1];
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         STOP: begin
            if (cnt_q == PULSE_LAST) begin
               // Back to IDLE at mid-stop-bit so a back-to-back start edge is not missed.
               cnt_d   = CNT_ZERO;
               state_d = IDLE;
               if (rxs_q) begin
                  // A frame being consumed this very cycle frees the slot for the new one.
                  if (!rx_valid_q || rx_ready) begin
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase

      // Disable wins over everything the FSM decided: silent abort, handshake untouched.
      if (!ena) begin
         state_d     = IDLE;
         cnt_d       = CNT_ZERO;
         rx_data_d   = rx_data_q;
         rx_valid_d  = hs_valid_s;
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // State and output registers with synchronous reset; synchronizer resets to the idle level.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= CNT_ZERO;
         idx_q       <= IDX_ZERO;
         shift_q     <= DATA_ZERO;
         rx_data_q   <= DATA_ZERO;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         meta_q      <= 1'b1;
         rxs_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         meta_q      <= meta_d;
         rxs_q       <= rxs_d;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx with CLK_FREQ=16, BAUD_RATE=1
// (16 clocks per bit). A frame-level reference model tracks what the consumer
// should see: each good frame either fills the empty output slot or counts as
// an overrun, each bad stop bit counts as a framing error.

module tb_uart_rx;

   localparam int PW = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       ena;
   logic       rxd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int checks   = 0;
   int failures = 0;

   // Pulse-cycle counters observed from the DUT.
   int fe_seen = 0;
   int ov_seen = 0;

   // Reference model state.
   logic       m_valid;
   logic [7:0] m_data;
   int         m_fe;
   int         m_ov;

   always #5 clk = ~clk;

   uart_rx #(
      .DATA_WIDTH (8),
      .BAUD_RATE  (1),
      .CLK_FREQ   (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ena       (ena),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   // Count every cycle each pulse output is high, sampled just after the edge.
   always @(posedge clk) begin
      #1;
      if (frame_err === 1'b1) fe_seen++;
      if (overrun === 1'b1) ov_seen++;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_frame(input logic [7:0] d, input logic stop);
      if (!stop) m_fe++;
      else if (!m_valid) begin
         m_valid = 1'b1;
         m_data  = d;
      end else m_ov++;
   endtask

   // Drive one frame; if ena_drop_bit >= 0, ena falls at the start of that data bit.
   task automatic send_frame(input logic [7:0] d, input logic stop,
                             input int ena_drop_bit, input int gap);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = bits[i];
         if (ena_drop_bit >= 0 && i == ena_drop_bit + 1) ena = 1'b0;
         repeat (PW) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   task automatic consume();
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      m_valid  = 1'b0;
   endtask

   task automatic test_reset();
      rxd = 1'b1; ena = 1'b1; rx_ready = 1'b0; reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
      reset = 1'b0;
      m_valid = 1'b0; m_data = 8'h00; m_fe = 0; m_ov = 0;
      repeat (5) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%b exp=0", rx_valid); end
   endtask

   task automatic test_basic();
      send_frame(8'hA5, 1'b1, -1, 2);
      model_frame(8'hA5, 1'b1);
      checks++; if (rx_valid !== m_valid) begin failures++; $display("FAIL basic_valid got=%b exp=%b", rx_valid, m_valid); end
      checks++; if (rx_data !== m_data) begin failures++; $display("FAIL basic_data got=%h exp=%h", rx_data, m_data); end
      repeat (30) @(negedge clk);
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL basic_hold got=%b exp=1", rx_valid); end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      m_valid = 1'b0;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_clear got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL basic_data_kept got=%h exp=a5", rx_data); end
   endtask

   task automatic test_ready_idle();
      rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      rx_ready = 1'b0;
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ready_idle_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== m_data) begin failures++; $display("FAIL ready_idle_data got=%h exp=%h", rx_data, m_data); end
   endtask

   task automatic test_glitch();
      int fe0, ov0;
      logic [7:0] d;
      fe0 = fe_seen; ov0 = ov_seen;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
      checks++; if (fe_seen - fe0 != 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", fe_seen - fe0); end
      checks++; if (ov_seen - ov0 != 0) begin failures++; $display("FAIL glitch_overrun got=%0d exp=0", ov_seen - ov0); end
      d = 8'($urandom);
      send_frame(d, 1'b1, -1, 2);
      model_frame(d, 1'b1);
      checks++; if (rx_valid !== m_valid || rx_data !== m_data) begin failures++; $display("FAIL glitch_after got=%b/%h exp=%b/%h", rx_valid, rx_data, m_valid, m_data); end
      consume();
   endtask

   task automatic test_frame_err();
      int fe0;
      logic [7:0] prev;
      fe0 = fe_seen; prev = rx_data;
      send_frame(8'h3C, 1'b0, -1, 20);
      model_frame(8'h3C, 1'b0);
      checks++; if (fe_seen - fe0 != 1) begin failures++; $display("FAIL frame_err_cycles got=%0d exp=1", fe_seen - fe0); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL frame_err_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== prev) begin failures++; $display("FAIL frame_err_data got=%h exp=%h", rx_data, prev); end
   endtask

   task automatic test_back_to_back();
      int ov0;
      ov0 = ov_seen;
      send_frame(8'h11, 1'b1, -1, 0);
      model_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1, -1, 2);
      model_frame(8'h22, 1'b1);
      checks++; if (rx_data !== 8'h11) begin failures++; $display("FAIL b2b_data got=%h exp=11", rx_data); end
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", rx_valid); end
      checks++; if (ov_seen - ov0 != 1) begin failures++; $display("FAIL b2b_overrun got=%0d exp=1", ov_seen - ov0); end
      consume();
   endtask

   task automatic test_ena_abort();
      int fe0, ov0;
      fe0 = fe_seen; ov0 = ov_seen;
      send_frame(8'($urandom), 1'b1, 3, 0);
      ena = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", rx_valid); end
      checks++; if (fe_seen - fe0 != 0 || ov_seen - ov0 != 0) begin failures++; $display("FAIL abort_pulses got=%0d/%0d exp=0/0", fe_seen - fe0, ov_seen - ov0); end
      send_frame(8'h5A, 1'b1, -1, 2);
      model_frame(8'h5A, 1'b1);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin failures++; $display("FAIL abort_next got=%b/%h exp=1/5a", rx_valid, rx_data); end
      consume();
   endtask

   task automatic test_reset_mid();
      logic [9:0] bits;
      send_frame(8'h42, 1'b1, -1, 2);
      model_frame(8'h42, 1'b1);
      bits = {1'b1, 8'hFF, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd = bits[i];
         if (i == 5) begin
            repeat (8) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            m_valid = 1'b0; m_data = 8'h00;
            checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
               failures++;
               $display("FAIL reset_mid_outputs got=%b/%h/%b/%b exp=0/00/0/0", rx_valid, rx_data, frame_err, overrun);
            end
            repeat (PW - 9) @(negedge clk);
         end else begin
            repeat (PW) @(negedge clk);
         end
      end
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_quiet got=%b exp=0", rx_valid); end
      send_frame(8'h81, 1'b1, -1, 2);
      model_frame(8'h81, 1'b1);
      checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin failures++; $display("FAIL reset_mid_next got=%b/%h exp=1/81", rx_valid, rx_data); end
      consume();
   endtask

   task automatic test_random();
      int fe_base, ov_base;
      logic [7:0] d;
      logic stop;
      fe_base = fe_seen; ov_base = ov_seen; m_fe = 0; m_ov = 0;
      for (int n = 0; n < 24; n++) begin
         d    = 8'($urandom);
         stop = ($urandom_range(0, 5) != 0);
         send_frame(d, stop, -1, stop ? $urandom_range(0, 4) : 20);
         model_frame(d, stop);
         if ($urandom_range(0, 2) == 0) consume();
         checks++; if (rx_valid !== m_valid) begin failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", n, rx_valid, m_valid); end
         if (m_valid) begin
            checks++; if (rx_data !== m_data) begin failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, rx_data, m_data); end
         end
         checks++; if (fe_seen - fe_base != m_fe || ov_seen - ov_base != m_ov) begin
            failures++;
            $display("FAIL rand_pulses[%0d] got=%0d/%0d exp=%0d/%0d", n, fe_seen - fe_base, ov_seen - ov_base, m_fe, m_ov);
         end
      end
      repeat (20) @(negedge clk);
      consume();
   endtask

   initial begin
      reset = 1'b1; ena = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_ready_idle();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_ena_abort();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
